board_io_ctrl: RTL and testbench

Parametrised board-side I/O controller between FPGA pins (slide switches, LEDs) and the SoC parallel GPIO ports. Synchronises and debounces N switch inputs, flags per-channel edges with a maskable sticky interrupt, and drives M LEDs from the SoC GPIO output with global PWM brightness control. Instantiated in board top-levels between the pins and `magma` `gpio_bi`/`gpio_bo`.

---
 rtl/board_io_pkg.sv | 14 +
 rtl/sw_debounce.sv | 52 +++++
 rtl/board_io_ctrl.sv | 83 ++++++++
 tb/tb_board_io_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared helpers for the board I/O controller: counter sizing and PWM constants.
package board_io_pkg;

    // Width able to count 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Duty value meaning "on for every slot of the PWM period".
    function automatic int pwm_full_on(input int bits);
        return 1 << bits;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Purpose: one switch channel; two-flop synchroniser, debounce counter, stable level, edge pulses.
// Latency: a held level reaches db_o DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running, outputs are levels and single-cycle pulses.
module sw_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
)
(
    input  logic clk_i,
    input  logic arst_i,
    input  logic sw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            db_o   <= 1'b0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            s1     <= sw_i;
            s2     <= s1;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            // Any return to the stable level restarts qualification from zero.
            if (s2 == db_o) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db_o   <= s2;
                cnt    <= '0;
                rise_o <= s2;
                fall_o <= ~s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// Purpose: switch debounce with sticky maskable edge interrupts, and PWM-dimmed LED drive from SoC GPIO.
// Latency: switches DEBOUNCE_CYCLES+2 edges, pending +1, irq +2; LEDs one registered cycle.
// Backpressure: none; all paths free-running, clears are write-1 pulses from the SoC.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PWM_BITS        = 4
)
(
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic [SW_WIDTH-1:0]  sw_i,
    output logic [SW_WIDTH-1:0]  sw_db_o,
    output logic [SW_WIDTH-1:0]  sw_rise_o,
    output logic [SW_WIDTH-1:0]  sw_fall_o,
    input  logic [SW_WIDTH-1:0]  irq_en_i,
    input  logic [SW_WIDTH-1:0]  irq_clr_i,
    output logic [SW_WIDTH-1:0]  irq_pend_o,
    output logic                 irq_o,
    input  logic [LED_WIDTH-1:0] gpio_bo_i,
    input  logic [PWM_BITS:0]    pwm_duty_i,
    output logic [LED_WIDTH-1:0] led_o
);

    localparam logic [PWM_BITS:0]   DUTY_FULL = (PWM_BITS + 1)'(pwm_full_on(PWM_BITS));
    localparam logic [PWM_BITS-1:0] CNT_LAST  = '1;

    // ---------------- switch channels ----------------
    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i  (clk_i),
            .arst_i (arst_i),
            .sw_i   (sw_i[i]),
            .db_o   (sw_db_o[i]),
            .rise_o (sw_rise_o[i]),
            .fall_o (sw_fall_o[i])
        );
    end

    // ---------------- interrupts ----------------
    logic [SW_WIDTH-1:0] edge_hit;
    assign edge_hit = (sw_rise_o | sw_fall_o) & irq_en_i;

    // A new edge outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            irq_pend_o <= '0;
            irq_o      <= 1'b0;
        end else begin
            irq_pend_o <= (irq_pend_o & ~irq_clr_i) | edge_hit;
            irq_o      <= |irq_pend_o;
        end
    end

    // ---------------- PWM LED drive ----------------
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS:0]   duty;
    logic                pwm_on;

    // Extra duty bit lets 2^PWM_BITS (and anything above) mean always on.
    assign pwm_on = ({1'b0, pwm_cnt} < duty);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pwm_cnt <= '0;
            duty    <= DUTY_FULL;
            led_o   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            // Duty only moves on the period boundary so no period is truncated.
            if (pwm_cnt == CNT_LAST) begin
                duty <= pwm_duty_i;
            end
            led_o <= gpio_bo_i & {LED_WIDTH{pwm_on}};
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Randomised bench for board_io_ctrl against a sliding-window / period-arithmetic reference model.
module tb_board_io_ctrl;

    localparam int SW  = 16;
    localparam int LED = 16;
    localparam int DB  = 4;
    localparam int PB  = 4;
    localparam int PER = 1 << PB;

    logic            clk_i = 1'b0;
    logic            arst_i;
    logic [SW-1:0]   sw_i;
    logic [SW-1:0]   sw_db_o;
    logic [SW-1:0]   sw_rise_o;
    logic [SW-1:0]   sw_fall_o;
    logic [SW-1:0]   irq_en_i;
    logic [SW-1:0]   irq_clr_i;
    logic [SW-1:0]   irq_pend_o;
    logic            irq_o;
    logic [LED-1:0]  gpio_bo_i;
    logic [PB:0]     pwm_duty_i;
    logic [LED-1:0]  led_o;

    always #5 clk_i = ~clk_i;

    board_io_ctrl #(
        .SW_WIDTH(SW), .LED_WIDTH(LED), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i), .sw_i(sw_i),
        .sw_db_o(sw_db_o), .sw_rise_o(sw_rise_o), .sw_fall_o(sw_fall_o),
        .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i), .irq_pend_o(irq_pend_o),
        .irq_o(irq_o), .gpio_bo_i(gpio_bo_i), .pwm_duty_i(pwm_duty_i), .led_o(led_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // hist[k] is the pin value sampled k edges ago (hist[0] = this edge).
    logic [SW-1:0]  hist [0:DB+1];
    logic [SW-1:0]  m_db, m_rise, m_fall, m_pend;
    logic           m_irq;
    logic [LED-1:0] m_led;
    int             m_phase;
    int             m_duty;

    task automatic model_reset();
        for (int k = 0; k <= DB + 1; k++) hist[k] = '0;
        m_db = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        m_irq = 1'b0; m_led = '0; m_phase = 0; m_duty = PER;
    endtask

    task automatic model_edge();
        logic [SW-1:0] nxt_pend;
        logic          nxt_irq;
        logic [LED-1:0] nxt_led;
        logic           accept;
        nxt_pend = (m_pend & ~irq_clr_i) | ((m_rise | m_fall) & irq_en_i);
        nxt_irq  = (m_pend != '0);
        nxt_led  = (m_phase < m_duty) ? gpio_bo_i : '0;
        if (m_phase == PER - 1) m_duty = int'(pwm_duty_i);
        m_phase = (m_phase + 1) % PER;
        for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sw_i;
        m_rise = '0;
        m_fall = '0;
        // A level is accepted once DB consecutive synchronised samples all differ from it.
        for (int b = 0; b < SW; b++) begin
            accept = 1'b1;
            for (int k = 2; k <= DB + 1; k++)
                if (hist[k][b] == m_db[b]) accept = 1'b0;
            if (accept) begin
                m_db[b]   = ~m_db[b];
                m_rise[b] = m_db[b];
                m_fall[b] = ~m_db[b];
            end
        end
        m_pend = nxt_pend;
        m_irq  = nxt_irq;
        m_led  = nxt_led;
    endtask

    task automatic check_all();
        chk("sw_db",   32'(sw_db_o),    32'(m_db));
        chk("sw_rise", 32'(sw_rise_o),  32'(m_rise));
        chk("sw_fall", 32'(sw_fall_o),  32'(m_fall));
        chk("pend",    32'(irq_pend_o), 32'(m_pend));
        chk("irq",     32'(irq_o),      32'(m_irq));
        chk("led",     32'(led_o),      32'(m_led));
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic cycle();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_all();
    endtask

    // Called at a falling edge; reset lands asynchronously between edges.
    task automatic apply_reset(input int hold);
        #2 arst_i = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (hold) begin
            @(negedge clk_i);
            check_all();
        end
        arst_i = 1'b0;
    endtask

    int led_on;
    logic [SW-1:0] flip;

    initial begin
        arst_i = 1'b1; sw_i = '0; irq_en_i = 16'h0001; irq_clr_i = '0;
        gpio_bo_i = 16'hFFFF; pwm_duty_i = 5'd16;
        model_reset();
        #1 check_all();
        @(negedge clk_i);
        arst_i = 1'b0;

        // held rise on ch0 and ch1: exact latency, only ch0 enabled for interrupts
        sw_i = 16'h0003;
        for (int n = 1; n <= 9; n++) begin
            cycle();
            if (n == 5) chk("lat5_db0", 32'(sw_db_o[0]), 32'd0);
            if (n == 6) chk("lat6_db0", 32'(sw_db_o[0]), 32'd1);
            if (n == 6) chk("lat6_rise0", 32'(sw_rise_o[0]), 32'd1);
            if (n == 7) chk("pend_ch0_only", 32'(irq_pend_o), 32'h0001);
            if (n == 8) chk("irq_set", 32'(irq_o), 32'd1);
        end

        // 3-cycle glitch on ch5 is swallowed
        sw_i[5] = 1'b1;
        repeat (3) cycle();
        sw_i[5] = 1'b0;
        repeat (8) cycle();
        chk("glitch_db5", 32'(sw_db_o[5]), 32'd0);

        // clear coincident with a new fall pulse on ch0: set wins
        sw_i[0] = 1'b0;
        for (int n = 0; n < 20 && !m_fall[0]; n++) cycle();
        chk("fall0_seen", 32'(sw_fall_o[0]), 32'd1);
        irq_clr_i = 16'h0001;
        cycle();
        chk("set_wins", 32'(irq_pend_o[0]), 32'd1);
        cycle();
        chk("clr_alone", 32'(irq_pend_o[0]), 32'd0);
        irq_clr_i = '0;
        cycle();
        chk("irq_drop", 32'(irq_o), 32'd0);

        // PWM duty 4 of 16, then full, off, and a mid-period change
        pwm_duty_i = 5'd4;
        repeat (PER) cycle();
        led_on = 0;
        repeat (4 * PER) begin
            cycle();
            if (led_o == 16'hFFFF) led_on++;
        end
        chk("duty4_on", 32'(led_on), 32'd16);
        pwm_duty_i = 5'd16;
        repeat (2 * PER) cycle();
        pwm_duty_i = 5'd0;
        repeat (2 * PER + 5) cycle();
        pwm_duty_i = 5'd9;
        repeat (2 * PER) cycle();

        // reset two cycles into debounce of a held switch, then full re-qualification
        sw_i = 16'h0008;
        repeat (2) cycle();
        apply_reset(2);
        repeat (9) cycle();
        chk("requal_db3", 32'(sw_db_o), 32'h0008);

        // all channels toggle together with every interrupt enabled
        irq_en_i = '1;
        irq_clr_i = '1;
        cycle();
        irq_clr_i = '0;
        sw_i = ~sw_i;
        repeat (8) cycle();
        chk("all_pend", 32'(irq_pend_o), 32'hFFFF);

        // randomised traffic
        for (int t = 0; t < 4000; t++) begin
            flip = '0;
            for (int b = 0; b < SW; b++)
                if ($urandom_range(0, 5) == 0) flip[b] = 1'b1;
            if ($urandom_range(0, 3) == 0) sw_i = sw_i ^ flip;
            if ($urandom_range(0, 49) == 0) irq_en_i = SW'($urandom);
            irq_clr_i = ($urandom_range(0, 9) == 0) ? SW'($urandom) : '0;
            gpio_bo_i = LED'($urandom);
            if ($urandom_range(0, 19) == 0) pwm_duty_i = (PB + 1)'($urandom_range(0, 31));
            if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(0, 2));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
